// File: rtl/bp_me_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_mem_responder_pkg
// Description : Shared types for the ME memory responder: memory message
//               encoding, responder FSM states and the command/response
//               header struct macro.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_me_mem_responder_pkg;

  // Memory command / response message type (all four encodings are defined)
  typedef enum logic [1:0] {
    E_MEM_BLOCK_RD = 2'd0,
    E_MEM_BLOCK_WR = 2'd1,
    E_MEM_UC_RD    = 2'd2,
    E_MEM_UC_WR    = 2'd3
  } mem_msg_e;

  // Responder FSM states
  typedef enum logic [1:0] {
    E_READY = 2'd0,
    E_WAIT  = 2'd1,
    E_RESP  = 2'd2
  } resp_state_e;

  // Width of one uncached word
  localparam int C_WORD_W = 64;

endpackage

// Header carried by both mem_cmd and mem_resp; the address width is a
// per-instance parameter, so the struct is stamped out where it is used.
`ifndef BP_ME_MEM_HDR_S
`define BP_ME_MEM_HDR_S
`define BP_ME_MEM_HDR_STRUCT(addr_w, struct_name) \
  typedef struct packed {                     \
    mem_msg_e             msg;                \
    logic [addr_w-1:0]    addr;               \
  } struct_name
`endif

`default_nettype wire

// File: rtl/bp_me_mem_responder_storage.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_mem_responder_storage
// Description : num_blocks_p x block_width_p storage array with one
//               read/write port. Writes are synchronous with a 64-bit word
//               write mask; the read path is combinational so the block
//               addressed in the accept cycle is visible in that same cycle.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_mem_responder_storage
  import bp_me_mem_responder_pkg::*;
#(
  parameter int block_width_p = 512,
  parameter int num_blocks_p  = 64
) (
  input  logic                              clk_i,
  input  logic                              w_i,
  input  logic [$clog2(num_blocks_p)-1:0]   addr_i,
  input  logic [block_width_p/C_WORD_W-1:0] wmask_i,
  input  logic [block_width_p-1:0]          data_i,
  output logic [block_width_p-1:0]          data_o
);

  localparam int C_WORDS = block_width_p / C_WORD_W;

  logic [block_width_p-1:0] mem_q [num_blocks_p];

  // Word-masked write of the addressed block
  always_ff @(posedge clk_i) begin
    if (w_i) begin
      for (int w = 0; w < C_WORDS; w++) begin
        if (wmask_i[w]) begin
          mem_q[addr_i][w*C_WORD_W +: C_WORD_W] <= data_i[w*C_WORD_W +: C_WORD_W];
        end
      end
    end
  end

  assign data_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/bp_me_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_mem_responder
// Description : Responder end of the ME memory interface. Accepts one memory
//               command at a time, commits writes / samples reads at
//               acceptance, and presents the response latency_p cycles later,
//               holding it until the consumer yumis it.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_mem_responder
  import bp_me_mem_responder_pkg::*;
#(
  parameter int paddr_width_p = 22,
  parameter int block_width_p = 512,
  parameter int num_blocks_p  = 64,
  parameter int latency_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  input  logic [1:0]               mem_cmd_msg_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic [block_width_p-1:0] mem_cmd_data_i,

  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,
  output logic [1:0]               mem_resp_msg_o,
  output logic [paddr_width_p-1:0] mem_resp_addr_o,
  output logic [block_width_p-1:0] mem_resp_data_o
);

  localparam int C_WORDS      = block_width_p / C_WORD_W;
  localparam int C_BLK_OFF    = $clog2(block_width_p / 8);
  localparam int C_BLK_IDX_W  = $clog2(num_blocks_p);
  localparam int C_WORD_IDX_W = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
  localparam int C_CNT_W      = (latency_p > 1) ? $clog2(latency_p) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(latency_p - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  `BP_ME_MEM_HDR_STRUCT(paddr_width_p, mem_hdr_s);

  resp_state_e              state_q, state_d;
  mem_hdr_s                 hdr_q, hdr_d;
  logic [block_width_p-1:0] data_q, data_d;
  logic [C_CNT_W-1:0]       cnt_q, cnt_d;

  mem_hdr_s                 w_cmd_hdr;
  logic                     w_cmd_fire;
  logic [C_BLK_IDX_W-1:0]   w_blk_idx;
  logic [C_WORD_IDX_W-1:0]  w_word_idx;
  logic                     w_we;
  logic [C_WORDS-1:0]       w_wmask;
  logic [block_width_p-1:0] w_wdata;
  logic [block_width_p-1:0] w_rd_block;
  logic [C_WORD_W-1:0]      w_rd_word;

  // Flat ports are cast into the shared header type
  assign w_cmd_hdr  = '{msg: mem_msg_e'(mem_cmd_msg_i), addr: mem_cmd_addr_i};
  assign w_cmd_fire = mem_cmd_v_i & mem_cmd_ready_o;

  // Upper address bits fall away here, which is what makes addresses alias
  assign w_blk_idx = mem_cmd_addr_i[C_BLK_OFF +: C_BLK_IDX_W];

  if (C_WORDS > 1) begin : g_word_idx_multi
    assign w_word_idx = mem_cmd_addr_i[3 +: C_WORD_IDX_W];
  end else begin : g_word_idx_single
    assign w_word_idx = '0;
  end

  assign w_rd_word = w_rd_block[w_word_idx*C_WORD_W +: C_WORD_W];

  // Storage write controls: writes commit in the accept cycle
  always_comb begin
    w_we    = 1'b0;
    w_wmask = '0;
    w_wdata = mem_cmd_data_i;
    if (w_cmd_fire) begin
      case (w_cmd_hdr.msg)
        E_MEM_BLOCK_WR: begin
          w_we    = 1'b1;
          w_wmask = '1;
        end
        E_MEM_UC_WR: begin
          w_we                = 1'b1;
          w_wmask[w_word_idx] = 1'b1;
          w_wdata             = {C_WORDS{mem_cmd_data_i[C_WORD_W-1:0]}};
        end
        default: ;
      endcase
    end
  end

  bp_me_mem_responder_storage #(
    .block_width_p(block_width_p),
    .num_blocks_p (num_blocks_p)
  ) storage (
    .clk_i  (clk_i),
    .w_i    (w_we),
    .addr_i (w_blk_idx),
    .wmask_i(w_wmask),
    .data_i (w_wdata),
    .data_o (w_rd_block)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= E_READY;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      E_READY: if (w_cmd_fire)      state_d = (latency_p > 1) ? E_WAIT : E_RESP;
      E_WAIT:  if (cnt_q == C_CNT_ONE) state_d = E_RESP;
      E_RESP:  if (mem_resp_yumi_i) state_d = E_READY;
      default:                      state_d = E_READY;
    endcase
  end

  // FSM outputs: handshake signals come straight from state, never from yumi
  always_comb begin
    mem_cmd_ready_o = (state_q == E_READY);
    mem_resp_v_o    = (state_q == E_RESP);
  end

  // Response header/data capture and latency countdown
  always_comb begin
    hdr_d  = hdr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (w_cmd_fire) begin
      hdr_d = w_cmd_hdr;
      cnt_d = C_CNT_LOAD;
      data_d = '0;
      case (w_cmd_hdr.msg)
        E_MEM_BLOCK_RD: data_d = w_rd_block;
        E_MEM_UC_RD:    data_d[C_WORD_W-1:0] = w_rd_word;
        default: ;
      endcase
    end else if (state_q == E_WAIT) begin
      cnt_d = cnt_q - C_CNT_ONE;
    end
  end

  // Response and counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_q  <= '{msg: E_MEM_BLOCK_RD, addr: '0};
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      hdr_q  <= hdr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_resp_msg_o  = hdr_q.msg;
  assign mem_resp_addr_o = hdr_q.addr;
  assign mem_resp_data_o = data_q;

`ifndef SYNTHESIS
  // A yumi outside RESP is a protocol violation; the FSM ignores it
  yumi_only_in_resp: assert property (
    @(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> (state_q == E_RESP)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_me_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_me_mem_responder
// Description : Self-checking bench for bp_me_mem_responder. Two instances
//               (latency 4 and latency 1) are driven through directed and
//               random command sequences and compared against a word-level
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_mem_responder;

  localparam int AW  = 22;
  localparam int BW  = 512;
  localparam int NB  = 64;
  localparam int WPB = BW / 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;
  logic [1:0]           cmd_v, yumi, ready, resp_v;
  logic [1:0][1:0]      cmd_msg, resp_msg;
  logic [1:0][AW-1:0]   cmd_addr, resp_addr;
  logic [1:0][BW-1:0]   cmd_data, resp_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference memory: 64-bit words, word n of block b at b*WPB+n
  logic [63:0] mw [2][NB*WPB];

  bp_me_mem_responder #(.paddr_width_p(AW), .block_width_p(BW),
                        .num_blocks_p(NB), .latency_p(4)) dut0 (
    .clk_i(clk), .reset_i(reset_i),
    .mem_cmd_v_i(cmd_v[0]), .mem_cmd_ready_o(ready[0]),
    .mem_cmd_msg_i(cmd_msg[0]), .mem_cmd_addr_i(cmd_addr[0]),
    .mem_cmd_data_i(cmd_data[0]),
    .mem_resp_v_o(resp_v[0]), .mem_resp_yumi_i(yumi[0]),
    .mem_resp_msg_o(resp_msg[0]), .mem_resp_addr_o(resp_addr[0]),
    .mem_resp_data_o(resp_data[0]));

  bp_me_mem_responder #(.paddr_width_p(AW), .block_width_p(BW),
                        .num_blocks_p(NB), .latency_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i),
    .mem_cmd_v_i(cmd_v[1]), .mem_cmd_ready_o(ready[1]),
    .mem_cmd_msg_i(cmd_msg[1]), .mem_cmd_addr_i(cmd_addr[1]),
    .mem_cmd_data_i(cmd_data[1]),
    .mem_resp_v_o(resp_v[1]), .mem_resp_yumi_i(yumi[1]),
    .mem_resp_msg_o(resp_msg[1]), .mem_resp_addr_o(resp_addr[1]),
    .mem_resp_data_o(resp_data[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] r;
    for (int i = 0; i < BW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Applies a command to the reference memory and returns the expected
  // response data. Block = (addr / 64) mod NB, word = (addr / 8) mod WPB.
  function automatic logic [BW-1:0] model_access(input int d, input logic [1:0] msg,
                                                 input logic [AW-1:0] addr,
                                                 input logic [BW-1:0] data);
    int a    = int'(addr);
    int blk  = (a / 64) % NB;
    int word = (a / 8) % WPB;
    logic [BW-1:0] r = '0;
    case (msg)
      2'd0: for (int w = 0; w < WPB; w++) r[w*64 +: 64] = mw[d][blk*WPB + w];
      2'd1: for (int w = 0; w < WPB; w++) mw[d][blk*WPB + w] = data[w*64 +: 64];
      2'd2: r[63:0] = mw[d][blk*WPB + word];
      default: mw[d][blk*WPB + word] = data[63:0];
    endcase
    return r;
  endfunction

  // One full command/response transaction with latency, stability and
  // handshake checks; hold = extra cycles yumi is withheld in RESP.
  task automatic do_cmd(input int d, input logic [1:0] msg, input logic [AW-1:0] addr,
                        input logic [BW-1:0] data, input int hold,
                        output logic [BW-1:0] got);
    logic [BW-1:0] exp;
    int lat = lat_of(d);
    @(negedge clk);
    check1("ready_before_cmd", ready[d], 1'b1);
    cmd_v[d] = 1'b1; cmd_msg[d] = msg; cmd_addr[d] = addr; cmd_data[d] = data;
    exp = model_access(d, msg, addr, data);
    @(posedge clk);
    @(negedge clk);
    cmd_v[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check1("resp_v_early", resp_v[d], 1'b0);
      check1("ready_in_wait", ready[d], 1'b0);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check1("resp_v_at_latency", resp_v[d], 1'b1);
      check1("ready_in_resp", ready[d], 1'b0);
      checkw("resp_msg", BW'(resp_msg[d]), BW'(msg));
      checkw("resp_addr", BW'(resp_addr[d]), BW'(addr));
      checkw("resp_data", resp_data[d], exp);
    end
    got = resp_data[d];
    yumi[d] = 1'b1;
    @(posedge clk);
    #1 yumi[d] = 1'b0;
    @(negedge clk);
    check1("ready_after_yumi", ready[d], 1'b1);
    check1("resp_v_after_yumi", resp_v[d], 1'b0);
  endtask

  initial begin
    logic [BW-1:0] got, pat, blk, wdat, exp_merge;
    logic [AW-1:0] a;
    logic          saw;

    cmd_v = '0; yumi = '0; cmd_msg = '0; cmd_addr = '0; cmd_data = '0;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    // Reset state and idle
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check1("reset_ready", ready[d], 1'b1);
      check1("reset_resp_v", resp_v[d], 1'b0);
      checkw("reset_resp_data", resp_data[d], '0);
      checkw("reset_resp_addr", BW'(resp_addr[d]), '0);
    end
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_v != 2'b00) saw = 1'b1;
    end
    check1("idle_no_resp", saw, 1'b0);

    // Fill both storages so every later read has a defined model value
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < 2; d++) do_cmd(d, 2'd1, AW'(b*64), rand_block(), 0, got);

    // Block write/read round trip
    for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + i;
    do_cmd(0, 2'd1, 22'h40, pat, 0, got);
    checkw("blk_wr_data_zero", got, '0);
    do_cmd(0, 2'd0, 22'h40, rand_block(), 0, got);
    checkw("blk_rd_pattern", got, pat);

    // Uncached merge into an all-ones block, with backpressure on the last read
    do_cmd(0, 2'd1, 22'h80, '1, 0, got);
    wdat = rand_block();
    wdat[63:0] = 64'h1234;
    do_cmd(0, 2'd3, 22'h98, wdat, 0, got);
    do_cmd(0, 2'd0, 22'h80, '0, 0, got);
    exp_merge = '1;
    exp_merge[255:192] = 64'h1234;
    checkw("merge_block", got, exp_merge);
    do_cmd(0, 2'd2, 22'h98, '0, 10, got);
    checkw("uc_rd_zext", got, BW'(64'h1234));

    // Random traffic on the latency-4 instance (full address range aliases)
    repeat (30) begin
      a = AW'($urandom);
      do_cmd(0, 2'($urandom_range(0, 3)), a, rand_block(), $urandom_range(0, 3), got);
    end

    // Latency 1 and aliasing
    blk = rand_block();
    do_cmd(1, 2'd1, 22'h40, blk, 0, got);
    do_cmd(1, 2'd0, AW'(32'h40 + NB*64), '0, 0, got);
    checkw("alias_read", got, blk);
    repeat (20) begin
      a = AW'($urandom);
      do_cmd(1, 2'($urandom_range(0, 3)), a, rand_block(), $urandom_range(0, 2), got);
    end

    // Reset during WAIT: write is committed, no response appears
    blk = rand_block();
    @(negedge clk);
    cmd_v[0] = 1'b1; cmd_msg[0] = 2'd1; cmd_addr[0] = 22'h200; cmd_data[0] = blk;
    got = model_access(0, 2'd1, 22'h200, blk);
    @(posedge clk);
    @(negedge clk);
    cmd_v[0] = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    #1 check1("reset_in_wait_resp_v", resp_v[0], 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check1("ready_after_wait_reset", ready[0], 1'b1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_v[0]) saw = 1'b1;
    end
    check1("no_stale_resp_wait", saw, 1'b0);

    // Reset during RESP: valid drops without waiting for a clock
    @(negedge clk);
    cmd_v[0] = 1'b1; cmd_msg[0] = 2'd0; cmd_addr[0] = 22'h200;
    @(posedge clk);
    @(negedge clk);
    cmd_v[0] = 1'b0;
    repeat (lat_of(0) - 1) @(negedge clk);
    check1("resp_v_before_reset", resp_v[0], 1'b1);
    #2 reset_i = 1'b1;
    #1 check1("reset_in_resp_resp_v", resp_v[0], 1'b0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check1("ready_after_resp_reset", ready[0], 1'b1);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_v[0]) saw = 1'b1;
    end
    check1("no_stale_resp_resp", saw, 1'b0);

    do_cmd(0, 2'd0, 22'h200, '0, 0, got);
    checkw("write_survives_reset", got, blk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
